// File: rtl/cache_assoc_ctrl_if.sv
// CPU word port and memory block port of the set-associative cache.
// The cache is the slave of the CPU bus and the master of the memory bus.
interface cpu_bus_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              hit_miss;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, hit_miss
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, hit_miss
    );
endinterface

interface mem_bus_if #(
    parameter int ADDR_W = 10,
    parameter int BLK_W  = 128
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back, write-allocate cache with true-LRU.
// Four-state FSM: IDLE, COMPARE, WRITEBACK, ALLOCATE; all outputs registered.
module cache_assoc_ctrl #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 2,
    parameter int NUM_WAYS        = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    cpu_bus_if.slave  cpu,
    mem_bus_if.master mem
);
    localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W  = DATA_W * WORDS_PER_BLOCK;
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_missed;
    logic [WAY_W-1:0]    r_victim;
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
    logic [WAY_W-1:0]    r_age   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0]    r_data  [NUM_SETS][NUM_WAYS];

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WOFF_W-1:0] w_woff;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_hit_age;
    logic              w_has_inv;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_old_way;
    logic [WAY_W-1:0]  w_victim;
    logic [DATA_W-1:0] w_hit_word;
    logic              w_unused;

    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx    = r_addr[OFF_W +: IDX_W];
    assign w_woff   = r_addr[2 +: WOFF_W];
    assign w_unused = ^r_addr[1:0];

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_old_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
            if (r_age[w_idx][w] == OLDEST) begin
                w_old_way = WAY_W'(w);
            end
        end
    end

    assign w_victim   = w_has_inv ? w_inv_way : w_old_way;
    assign w_hit_age  = r_age[w_idx][w_hit_way];
    assign w_hit_word = r_data[w_idx][w_hit_way][w_woff*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_missed      <= 1'b0;
            r_victim      <= '0;
            cpu.cpu_ready <= 1'b0;
            cpu.cpu_rdata <= '0;
            cpu.hit_miss  <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            cpu.cpu_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cpu.cpu_req) begin
                        r_we     <= cpu.cpu_we;
                        r_addr   <= cpu.cpu_addr;
                        r_wdata  <= cpu.cpu_wdata;
                        r_missed <= 1'b0;
                        r_state  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        cpu.cpu_ready <= 1'b1;
                        cpu.hit_miss  <= !r_missed;
                        if (r_we) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end else begin
                            cpu.cpu_rdata <= w_hit_word;
                        end
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_W'(w) == w_hit_way) begin
                                r_age[w_idx][w] <= '0;
                            end else if (r_age[w_idx][w] < w_hit_age) begin
                                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                            end
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_missed    <= 1'b1;
                        r_victim    <= w_victim;
                        mem.mem_req <= 1'b1;
                        if (r_dirty[w_idx][w_victim]) begin
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= {r_tag[w_idx][w_victim], w_idx,
                                              {OFF_W{1'b0}}};
                            mem.mem_wdata <= r_data[w_idx][w_victim];
                            r_state       <= S_WRITEBACK;
                        end else begin
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_state      <= S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // Fill request follows the write-back with no idle gap.
                    if (mem.mem_ack) begin
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        r_state      <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem.mem_ack) begin
                        mem.mem_req              <= 1'b0;
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_state                  <= S_COMPARE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line contents carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if ((r_state == S_ALLOCATE) && mem.mem_ack) begin
            r_data[w_idx][r_victim] <= mem.mem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end else if ((r_state == S_COMPARE) && w_hit && r_we) begin
            r_data[w_idx][w_hit_way][w_woff*DATA_W +: DATA_W] <= r_wdata;
        end
    end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed vector bench for cache_assoc_ctrl with a behavioural memory.
// Table of accesses plus a hand-written reset-during-allocate sequence.
module tb_cache_assoc_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BLK_W  = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu ();
    mem_bus_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W))   u_mem ();

    cache_assoc_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLOCK(4),
        .NUM_SETS(2), .NUM_WAYS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu(u_cpu), .mem(u_mem)
    );

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_wb;
        logic [9:0]  wb_addr;
        int          wb_word;
        logic [31:0] wb_val;
        logic        exp_rd;
        logic [9:0]  rd_addr;
        int          delay;
        logic        poke;
    } vec_t;

    vec_t         vecs [20];
    logic [127:0] mem_model [64];
    int           errors = 0;
    int           checks = 0;

    function automatic vec_t mk(input logic we, input logic [9:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic hit, input logic ewb,
                                input logic [9:0] wba, input int wbw,
                                input logic [31:0] wbv, input logic erd,
                                input logic [9:0] rda, input int dly,
                                input logic poke);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.exp_rdata = rd;
        v.exp_hit = hit; v.exp_wb = ewb; v.wb_addr = wba;
        v.wb_word = wbw; v.wb_val = wbv; v.exp_rd = erd;
        v.rd_addr = rda; v.delay = dly; v.poke = poke;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input int id);
        int          cyc, wait_n, ack_cyc, n_wb, n_rd;
        bit          done, in_txn, gap_chk;
        logic [9:0]  wb_a, rd_a, cur_a;
        logic        cur_we;
        logic [127:0] cur_d, wb_d;
        string       nm;
        nm = $sformatf("v%0d", id);
        cyc = 0; wait_n = 0; ack_cyc = 0; n_wb = 0; n_rd = 0;
        done = 0; in_txn = 0; gap_chk = 0;
        wb_a = '0; rd_a = '0; cur_a = '0; cur_we = 0;
        cur_d = '0; wb_d = '0;
        @(negedge clk);
        u_cpu.cpu_req = 1'b1;
        u_cpu.cpu_we = v.we;
        u_cpu.cpu_addr = v.addr;
        u_cpu.cpu_wdata = v.wdata;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 100) begin
            u_mem.mem_ack = 1'b0;
            u_cpu.cpu_req = 1'b0;
            if (gap_chk) begin
                chk({nm, " wb-to-fill req"}, {u_mem.mem_req, u_mem.mem_we},
                    2'b10);
                gap_chk = 0;
            end
            if (u_cpu.cpu_ready) begin
                done = 1;
                chk({nm, " latency"}, cyc - ack_cyc, 2);
                chk({nm, " hit_miss"}, u_cpu.hit_miss, v.exp_hit);
                chk({nm, " rdata"}, u_cpu.cpu_rdata, v.exp_rdata);
                chk({nm, " wb count"}, n_wb, v.exp_wb);
                chk({nm, " rd count"}, n_rd, v.exp_rd);
                if (v.exp_wb) begin
                    chk({nm, " wb addr"}, wb_a, v.wb_addr);
                    chk({nm, " wb word"}, wb_d[v.wb_word*32 +: 32], v.wb_val);
                end
                if (v.exp_rd) chk({nm, " rd addr"}, rd_a, v.rd_addr);
            end else if (u_mem.mem_req) begin
                if (!in_txn) begin
                    in_txn = 1; wait_n = 0;
                    cur_a = u_mem.mem_addr;
                    cur_we = u_mem.mem_we;
                    cur_d = u_mem.mem_wdata;
                    if (cur_we) begin
                        n_wb++; wb_a = cur_a; wb_d = cur_d;
                    end else begin
                        n_rd++; rd_a = cur_a;
                    end
                end else begin
                    chk({nm, " mem stable"},
                        {u_mem.mem_we, u_mem.mem_addr,
                         cur_we ? u_mem.mem_wdata : cur_d},
                        {cur_we, cur_a, cur_d});
                end
                if (v.poke && wait_n == 2) begin
                    u_cpu.cpu_req = 1'b1;
                    u_cpu.cpu_we = 1'b0;
                    u_cpu.cpu_addr = 10'h3F0;
                end
                if (wait_n >= v.delay) begin
                    u_mem.mem_ack = 1'b1;
                    if (cur_we) begin
                        mem_model[cur_a[9:4]] = cur_d;
                        gap_chk = 1;
                    end else begin
                        u_mem.mem_rdata = mem_model[cur_a[9:4]];
                    end
                    in_txn = 0;
                    ack_cyc = cyc;
                end else begin
                    wait_n++;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        u_mem.mem_ack = 1'b0;
        u_cpu.cpu_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no cpu_ready expected cpu_ready", nm);
        end
        repeat (2) begin
            @(negedge clk);
            chk({nm, " idle after ready"},
                {u_cpu.cpu_ready, u_mem.mem_req, u_cpu.hit_miss},
                {1'b0, 1'b0, v.exp_hit});
        end
    endtask

    initial begin
        int  n;
        logic saw;
        u_cpu.cpu_req = 0; u_cpu.cpu_we = 0;
        u_cpu.cpu_addr = '0; u_cpu.cpu_wdata = '0;
        u_mem.mem_ack = 0; u_mem.mem_rdata = '0;
        for (int b = 0; b < 64; b++)
            for (int k = 0; k < 4; k++)
                mem_model[b][k*32 +: 32] = (32'h11111111 * 32'(k)) +
                                           (32'(b) << 16);

        //            we addr    wdata         rdata         hit wb wba  w  wbval        rd rda   dly poke
        vecs[0]  = mk(0, 10'h000, 0,            32'h00000000, 0, 0, 0,    0, 0,            1, 10'h000, 0, 0);
        vecs[1]  = mk(0, 10'h004, 0,            32'h11111111, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[2]  = mk(1, 10'h008, 32'hDEADBEEF, 32'h11111111, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[3]  = mk(0, 10'h008, 0,            32'hDEADBEEF, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[4]  = mk(0, 10'h000, 0,            32'h00000000, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[5]  = mk(0, 10'h020, 0,            32'h00020000, 0, 0, 0,    0, 0,            1, 10'h020, 1, 0);
        vecs[6]  = mk(0, 10'h000, 0,            32'h00000000, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[7]  = mk(0, 10'h040, 0,            32'h00040000, 0, 0, 0,    0, 0,            1, 10'h040, 2, 0);
        vecs[8]  = mk(0, 10'h000, 0,            32'h00000000, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[9]  = mk(0, 10'h020, 0,            32'h00020000, 0, 0, 0,    0, 0,            1, 10'h020, 0, 0);
        vecs[10] = mk(1, 10'h024, 32'hCAFEF00D, 32'h00020000, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[11] = mk(0, 10'h000, 0,            32'h00000000, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[12] = mk(0, 10'h040, 0,            32'h00040000, 0, 1, 10'h020, 1, 32'hCAFEF00D, 1, 10'h040, 5, 1);
        vecs[13] = mk(0, 10'h024, 0,            32'hCAFEF00D, 0, 1, 10'h000, 2, 32'hDEADBEEF, 1, 10'h020, 0, 0);
        vecs[14] = mk(0, 10'h008, 0,            32'hDEADBEEF, 0, 0, 0,    0, 0,            1, 10'h000, 1, 0);
        vecs[15] = mk(0, 10'h010, 0,            32'h00010000, 0, 0, 0,    0, 0,            1, 10'h010, 0, 0);
        vecs[16] = mk(0, 10'h01C, 0,            32'h33343333, 1, 0, 0,    0, 0,            0, 0,       0, 0);
        vecs[17] = mk(0, 10'h070, 0,            32'h00070000, 0, 0, 0,    0, 0,            1, 10'h070, 1, 0);
        vecs[18] = mk(0, 10'h010, 0,            32'h00010000, 0, 0, 0,    0, 0,            1, 10'h010, 0, 0);
        vecs[19] = mk(0, 10'h074, 0,            32'h11181111, 1, 0, 0,    0, 0,            0, 0,       0, 0);

        repeat (2) @(negedge clk);
        chk("reset cpu outs", {u_cpu.cpu_ready, u_cpu.cpu_rdata, u_cpu.hit_miss},
            '0);
        chk("reset mem ctl", {u_mem.mem_req, u_mem.mem_we, u_mem.mem_addr}, '0);
        chk("reset mem_wdata", u_mem.mem_wdata, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_access(vecs[i], i);

        // Reset while a fill is outstanding: request dropped, lines invalid.
        @(negedge clk);
        u_cpu.cpu_req = 1'b1; u_cpu.cpu_we = 1'b0; u_cpu.cpu_addr = 10'h070;
        @(negedge clk);
        u_cpu.cpu_req = 1'b0;
        n = 0;
        while (!u_mem.mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst alloc req", {u_mem.mem_req, u_mem.mem_we, u_mem.mem_addr},
            {1'b1, 1'b0, 10'h070});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst async mem_req", u_mem.mem_req, 1'b0);
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw = saw | u_cpu.cpu_ready | u_mem.mem_req;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            saw = saw | u_cpu.cpu_ready | u_mem.mem_req;
        end
        chk("rst no ready/req", saw, 1'b0);

        for (int i = 17; i < 20; i++) run_access(vecs[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_assoc_ctrl.md
# cache_assoc_ctrl

Parametrised, clocked N-way set-associative write-back, write-allocate cache with per-set true-LRU replacement.
- Sits between the CPU data port and main memory.
- CPU side uses a word-level request/ready handshake.
- Memory side uses a block-level request/acknowledge handshake, so memory latency is arbitrary.
- Replaces the single-cycle, delay-based 2-way cache with a synthesisable FSM.

## Interface
- ADDR_W, 10, byte-address width.
- DATA_W, 32, word width; must be 32 (byte offset is 2 bits).
- WORDS_PER_BLOCK, 4, words per line; power of two ≥ 2.
- NUM_SETS, 2, sets; power of two ≥ 2.
- NUM_WAYS, 2, ways per set; one of 2, 4, 8.
- Derived widths:
  - OFF_W = log2(WORDS_PER_BLOCK)+2.
  - IDX_W = log2(NUM_SETS).
  - TAG_W = ADDR_W−IDX_W−OFF_W.
  - BLK_W = DATA_W·WORDS_PER_BLOCK.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  0 read, 1 write.
- cpu_addr  in  ADDR_W  byte address. Fields: tag = [ADDR_W−1 : IDX_W+OFF_W], index, word offset, byte offset (ignored).
- cpu_wdata  in  DATA_W  write word.
- cpu_ready  out  1  one-cycle pulse: request complete.
- cpu_rdata  out  DATA_W  read word, valid while cpu_ready=1. Unchanged on writes.
- hit_miss  out  1  1 if the original lookup hit. Valid with cpu_ready; held until the next completion.
- mem_req  out  1  memory request.
- mem_we  out  1  0 block read, 1 block write-back.
- mem_addr  out  ADDR_W  block-aligned address (offset bits zero).
- mem_wdata  out  BLK_W  write-back block.
- mem_rdata  in  BLK_W  fill block, valid in the mem_ack cycle.
- mem_ack  in  1  memory completion, sampled only while mem_req=1.

## Operation
- Line state per way: valid, dirty, tag, data, age (log2(NUM_WAYS) bits).
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - cpu_req=1 at a rising edge latches cpu_we, cpu_addr and cpu_wdata, then moves to COMPARE.
  - cpu_req is ignored in every other state.
- COMPARE: all ways of the indexed set are compared in parallel.
  - Hit: read returns the word; write merges the word and sets dirty. Ages update, cpu_ready is pulsed, state returns to IDLE.
  - Miss, first pass: record miss (hit_miss result = 0) and select a victim:
    - the lowest-index invalid way; otherwise
    - the way with age = NUM_WAYS−1.
    - A dirty victim goes to WRITEBACK; otherwise to ALLOCATE.
- WRITEBACK:
  - Drives mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim data.
  - On mem_ack: clear victim dirty, go to ALLOCATE.
- ALLOCATE:
  - Drives mem_req=1, mem_we=0, mem_addr = {request tag, index, 0}.
  - On mem_ack: write mem_rdata, tag, valid=1, dirty=0; return to COMPARE, which now hits.
  - The write-miss merge therefore happens in COMPARE (write allocate).
- LRU age update on every completed access:
  - the accessed way's age becomes 0;
  - ways in the same set with age less than the accessed way's old age increment by 1;
  - other ways are unchanged.
  - Ages in a set always form a permutation of 0..NUM_WAYS−1.
- Reset:
  - all valid/dirty bits = 0; age of way w = w; state IDLE.
  - cpu_ready, cpu_rdata, hit_miss, mem_req, mem_we, mem_addr, mem_wdata = 0.
  - Data arrays are not reset.

## Timing
- All outputs are registered.
- Request accepted at edge N; COMPARE in cycle N+1; on a hit, cpu_ready=1 in cycle N+2.
  - Hit latency is 2 cycles.
  - A new request may be accepted at the end of cycle N+2 (back-to-back throughput: one request per 2 cycles).
- Miss:
  - mem_req rises in cycle N+2.
  - If mem_ack is sampled at edge M, mem_req=0 from cycle M+1.
- Clean miss: COMPARE in M+1, cpu_ready in M+2.
- Dirty miss: the second request (read) starts in cycle M+1 after the write-back ack. mem_req drops for zero cycles between the two requests; mem_we and mem_addr change.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req=1.
- mem_ack arriving in the same cycle mem_req rises is legal (1-cycle memory).
- Reset mid-miss: mem_req falls asynchronously. No line is modified, the request is dropped, and no cpu_ready is issued.
- Reset mid-writeback: the line is lost (valid cleared); accepted behaviour.

## Test plan
- Reset, then read 0x000:
  - mem_req=1, mem_we=0, mem_addr=0x000.
  - Ack with block {0x33333333, 0x22222222, 0x11111111, 0x00000000}.
  - Expect cpu_rdata=0x00000000, hit_miss=0.
  - Read 0x004: cpu_ready 2 cycles after accept, rdata=0x11111111, hit_miss=1, no mem_req.
- Write 0x008 ← 0xDEADBEEF (hit):
  - hit_miss=1, no memory traffic.
  - Read 0x008 returns 0xDEADBEEF.
- LRU, clean victim: read 0x000, then 0x020, then 0x000, then 0x040.
  - The miss on 0x040 issues only a read at 0x040; no write-back.
  - Read 0x000 then hits; read 0x020 misses.
- Dirty eviction: write 0x024 ← 0xCAFEF00D, read 0x000, read 0x040.
  - mem_we=1, mem_addr=0x020, mem_wdata[63:32]=0xCAFEF00D.
  - Then mem_we=0, mem_addr=0x040.
- Slow memory: mem_ack delayed 5 cycles.
  - mem_req, mem_addr and mem_wdata stay constant.
  - A cpu_req pulse during the miss is ignored; exactly one cpu_ready.
- rst_n low during ALLOCATE:
  - mem_req=0 immediately; no cpu_ready.
  - After release, read of the same address misses (hit_miss=0).
